// File: rtl/calc_pkg.sv
// Shared constants, state type and key-map helpers for the calculator
// keypad controller and its evaluation datapath.
package calc_pkg;

    localparam int MAX_LEN_DEF = 16;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_CLR   = 8'h43;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_BS    = 8'h42;

    typedef enum logic {
        IDLE,
        EVAL
    } state_t;

    // Row-major 4x4 keypad: "123+" / "456-" / "789*" / "C0=B".
    function automatic logic [7:0] key_char(input logic [1:0] row, input logic [1:0] col);
        logic [7:0] ch;
        case ({row, col})
            4'h0: ch = "1";
            4'h1: ch = "2";
            4'h2: ch = "3";
            4'h3: ch = CH_PLUS;
            4'h4: ch = "4";
            4'h5: ch = "5";
            4'h6: ch = "6";
            4'h7: ch = CH_MINUS;
            4'h8: ch = "7";
            4'h9: ch = "8";
            4'hA: ch = "9";
            4'hB: ch = CH_MUL;
            4'hC: ch = CH_CLR;
            4'hD: ch = "0";
            4'hE: ch = CH_EQ;
            default: ch = CH_BS;
        endcase
        return ch;
    endfunction

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= "0") && (ch <= "9");
    endfunction

    function automatic logic is_op(input logic [7:0] ch);
        return (ch == CH_PLUS) || (ch == CH_MINUS) || (ch == CH_MUL);
    endfunction

    function automatic logic [15:0] apply_op(input logic [15:0] a, input logic [7:0] op,
                                             input logic [15:0] b);
        logic [15:0] r;
        case (op)
            CH_MINUS: r = a - b;
            CH_MUL:   r = a * b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_eval.sv
// Character-at-a-time left-to-right accumulator; result is the value the
// expression would have if it ended at the current character.
module calc_eval
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        valid,
    input  logic        last,
    input  logic [7:0]  ch,
    output logic [15:0] result,
    output logic        done
);

    logic [15:0] acc_q, acc_d;
    logic [15:0] opnd_q, opnd_d;
    logic [7:0]  op_q, op_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            op_q   <= CH_PLUS;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        if (start) begin
            acc_d  = '0;
            opnd_d = '0;
            op_d   = CH_PLUS;
        end else if (valid && !last) begin
            if (is_digit(ch)) begin
                opnd_d = opnd_q * 16'd10 + {12'd0, ch[3:0]};
            end else if (is_op(ch)) begin
                acc_d  = apply_op(acc_q, op_q, opnd_q);
                op_d   = ch;
                opnd_d = '0;
            end
        end
    end

    assign result = apply_op(acc_q, op_q, opnd_q);
    assign done   = valid & last;

endmodule

// File: rtl/calc_ctrl.sv
// Keypad-side calculator controller: cursor, expression buffer, IDLE/EVAL
// FSM and the registered result shown on the LCD.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 clk_in,
    input  logic                 sys_rst,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_ok,
    output logic [3:0]           cursor_x,
    output logic [3:0]           cursor_y,
    output logic [8*MAX_LEN-1:0] disp_str_flat,
    output logic [15:0]          result,
    output logic                 calc_done,
    output logic                 busy
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t         state_q, state_d;
    logic [1:0]     row_q, row_d, col_q, col_d;
    logic [7:0]     buf_q [MAX_LEN];
    logic [7:0]     buf_d [MAX_LEN];
    logic [LW-1:0]  len_q, len_d, idx_q, idx_d;
    logic [15:0]    result_q, result_d;
    logic           done_q, done_d;

    logic [7:0]     key;
    logic [7:0]     eval_ch;
    logic           eval_start, eval_valid, eval_last, eval_done;
    logic [15:0]    eval_result;

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) buf_q[k] <= CH_SPACE;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            done_q   <= done_d;
            buf_q    <= buf_d;
        end
    end

    assign key = key_char(row_q, col_q);

    always_comb begin
        eval_ch = CH_SPACE;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (LW'(k) == idx_q) eval_ch = buf_q[k];
        end
    end

    // Buttons only act in IDLE; EVAL walks idx from 0 to len, finishing on idx==len.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        buf_d      = buf_q;
        len_d      = len_q;
        idx_d      = idx_q;
        result_d   = result_q;
        done_d     = done_q;
        eval_start = 1'b0;
        eval_valid = 1'b0;
        eval_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_ok) begin
                    if (key == CH_EQ) begin
                        state_d    = EVAL;
                        idx_d      = '0;
                        eval_start = 1'b1;
                    end else if (key == CH_CLR) begin
                        for (int k = 0; k < MAX_LEN; k++) buf_d[k] = CH_SPACE;
                        len_d    = '0;
                        result_d = '0;
                        done_d   = 1'b0;
                    end else if (key == CH_BS) begin
                        done_d = 1'b0;
                        if (len_q != '0) begin
                            for (int k = 0; k < MAX_LEN; k++) begin
                                if (LW'(k) + LW'(1) == len_q) buf_d[k] = CH_SPACE;
                            end
                            len_d = len_q - LW'(1);
                        end
                    end else begin
                        done_d = 1'b0;
                        if (len_q < LW'(MAX_LEN)) begin
                            for (int k = 0; k < MAX_LEN; k++) begin
                                if (LW'(k) == len_q) buf_d[k] = key;
                            end
                            len_d = len_q + LW'(1);
                        end
                    end
                end else if (btn_up) begin
                    row_d = row_q - 2'd1;
                end else if (btn_down) begin
                    row_d = row_q + 2'd1;
                end else if (btn_left) begin
                    col_d = col_q - 2'd1;
                end else if (btn_right) begin
                    col_d = col_q + 2'd1;
                end
            end
            EVAL: begin
                eval_valid = 1'b1;
                eval_last  = (idx_q == len_q);
                if (eval_done) begin
                    result_d = eval_result;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    calc_eval u_eval (
        .clk    (clk_in),
        .rst    (sys_rst),
        .start  (eval_start),
        .valid  (eval_valid),
        .last   (eval_last),
        .ch     (eval_ch),
        .result (eval_result),
        .done   (eval_done)
    );

    always_comb begin
        disp_str_flat = '0;
        for (int k = 0; k < MAX_LEN; k++) disp_str_flat[k*8 +: 8] = buf_q[k];
    end

    assign cursor_x  = {2'b00, col_q};
    assign cursor_y  = {2'b00, row_q};
    assign result    = result_q;
    assign calc_done = done_q;
    assign busy      = (state_q == EVAL);

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed, self-checking bench for calc_ctrl: table-driven cursor moves plus
// hand-written expression, overflow, busy-lockout and reset-abort sequences.
module tb_calc_ctrl;

    localparam int MAX_LEN = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 btn_up, btn_down, btn_left, btn_right, btn_ok;
    logic [3:0]           cursor_x, cursor_y;
    logic [8*MAX_LEN-1:0] disp_str_flat;
    logic [15:0]          result;
    logic                 calc_done, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_r    = 0;
    int cur_c    = 0;

    typedef struct {
        logic [4:0] btns;
        int         exp_x;
        int         exp_y;
    } nav_vec_t;

    // btns bit order: {ok, up, down, left, right}
    localparam logic [4:0] B_OK = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100,
                           B_LT = 5'b00010, B_RT = 5'b00001;

    always #5 clk = ~clk;

    calc_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk_in        (clk),
        .sys_rst       (rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_ok        (btn_ok),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .disp_str_flat (disp_str_flat),
        .result        (result),
        .calc_done     (calc_done),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] build_disp(input string s);
        logic [127:0] v;
        v = {16{8'h20}};
        for (int k = 0; k < s.len() && k < 16; k++) v[k*8 +: 8] = s[k];
        return v;
    endfunction

    task automatic driveBtns(input logic [4:0] b);
        {btn_ok, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // One button pattern sampled by exactly one rising edge; returns on the
    // following falling edge with outputs settled.
    task automatic applyStimulus(input logic [4:0] b);
        @(negedge clk);
        driveBtns(b);
        @(negedge clk);
        driveBtns(5'b0);
    endtask

    task automatic press_key(input byte ch);
        string map;
        int    pos;
        map = "123+456-789*C0=B";
        pos = -1;
        for (int k = 0; k < 16; k++) if (map[k] == ch) pos = k;
        if (pos < 0) begin
            $display("[TB] FAIL key_lookup: got %0h, expected a keypad char", ch);
            n_checks++;
            n_fail++;
            return;
        end
        for (int k = 0; k < 4 && cur_c != pos % 4; k++) begin
            applyStimulus(B_RT);
            cur_c = (cur_c + 1) % 4;
        end
        for (int k = 0; k < 4 && cur_r != pos / 4; k++) begin
            applyStimulus(B_DN);
            cur_r = (cur_r + 1) % 4;
        end
        applyStimulus(B_OK);
    endtask

    task automatic press_str(input string s);
        for (int k = 0; k < s.len(); k++) press_key(s[k]);
    endtask

    // Press "=" and verify cycle count from the "=" edge to calc_done.
    task automatic eval_expect(input string name, input int exp_res, input int exp_n);
        int n;
        int bcnt;
        press_key("=");
        n    = 0;
        bcnt = busy ? 1 : 0;
        while (!calc_done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bcnt++;
        end
        checkOutput({name, "_latency"}, 128'(n), 128'(exp_n));
        checkOutput({name, "_busy_cycles"}, 128'(bcnt), 128'(exp_n));
        checkOutput({name, "_result"}, 128'(result), 128'(exp_res));
        checkOutput({name, "_busy_end"}, 128'(busy), 128'(0));
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, "_x"}, 128'(cursor_x), 128'(0));
        checkOutput({name, "_y"}, 128'(cursor_y), 128'(0));
        checkOutput({name, "_disp"}, disp_str_flat, build_disp(""));
        checkOutput({name, "_result"}, 128'(result), 128'(0));
        checkOutput({name, "_done"}, 128'(calc_done), 128'(0));
        checkOutput({name, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        nav_vec_t vecs [16];
        logic [127:0] snap_disp;

        vecs[0]  = '{B_RT, 1, 0};
        vecs[1]  = '{B_RT, 2, 0};
        vecs[2]  = '{B_RT, 3, 0};
        vecs[3]  = '{B_RT, 0, 0};
        vecs[4]  = '{B_RT, 1, 0};
        vecs[5]  = '{B_UP, 1, 3};
        vecs[6]  = '{B_UP, 1, 2};
        vecs[7]  = '{B_UP, 1, 1};
        vecs[8]  = '{B_UP, 1, 0};
        vecs[9]  = '{B_UP, 1, 3};
        vecs[10] = '{B_UP, 1, 2};
        vecs[11] = '{B_UP | B_DN, 1, 1};
        vecs[12] = '{B_LT | B_RT, 0, 1};
        vecs[13] = '{B_LT, 3, 1};
        vecs[14] = '{B_DN | B_LT, 3, 2};
        vecs[15] = '{B_OK | B_UP, 3, 2};

        driveBtns(5'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset_asserted");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset_released");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].btns);
            checkOutput($sformatf("nav%0d_x", i), 128'(cursor_x), 128'(vecs[i].exp_x));
            checkOutput($sformatf("nav%0d_y", i), 128'(cursor_y), 128'(vecs[i].exp_y));
        end
        cur_c = vecs[15].exp_x;
        cur_r = vecs[15].exp_y;
        checkOutput("ok_beats_up_disp", disp_str_flat, build_disp("*"));

        press_str("C12+3*2");
        checkOutput("expr1_disp", disp_str_flat, build_disp("12+3*2"));
        checkOutput("expr1_done_before", 128'(calc_done), 128'(0));
        eval_expect("expr1", 30, 7);
        checkOutput("expr1_disp_kept", disp_str_flat, build_disp("12+3*2"));

        press_str("C9-12");
        eval_expect("sub_wrap", 65533, 5);
        press_str("C999*999");
        eval_expect("mul_trunc", 14961, 8);
        press_str("C5+");
        eval_expect("trailing_op", 5, 3);
        press_str("BB");
        checkOutput("bs_clears_done", 128'(calc_done), 128'(0));
        checkOutput("bs_keeps_result", 128'(result), 128'(5));
        eval_expect("empty", 0, 1);

        press_str("C11111111111111111");
        checkOutput("full_disp", disp_str_flat, build_disp("1111111111111111"));
        for (int i = 0; i < 17; i++) press_key("B");
        checkOutput("bs_underflow_disp", disp_str_flat, build_disp(""));
        press_key("2");
        checkOutput("after_underflow_disp", disp_str_flat, build_disp("2"));

        press_str("C7");
        eval_expect("seven", 7, 2);
        press_key("B");
        checkOutput("post_b_done", 128'(calc_done), 128'(0));
        checkOutput("post_b_result", 128'(result), 128'(7));
        press_key("C");
        checkOutput("post_c_result", 128'(result), 128'(0));

        // Buttons during EVAL, including on the exit edge, must be dropped.
        press_str("12+3*2=");
        snap_disp = build_disp("12+3*2");
        @(negedge clk);
        driveBtns(B_OK | B_RT);
        @(negedge clk);
        driveBtns(5'b0);
        repeat (4) @(negedge clk);
        driveBtns(B_OK | B_RT);
        @(negedge clk);
        driveBtns(5'b0);
        checkOutput("lock_done", 128'(calc_done), 128'(1));
        checkOutput("lock_result", 128'(result), 128'(30));
        checkOutput("lock_x", 128'(cursor_x), 128'(2));
        checkOutput("lock_disp", disp_str_flat, snap_disp);
        @(negedge clk);
        checkOutput("lock_busy_after", 128'(busy), 128'(0));
        checkOutput("lock_x_after", 128'(cursor_x), 128'(2));

        press_str("C9*9*9=");
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        cur_r = 0;
        cur_c = 0;
        repeat (3) @(negedge clk);
        check_reset_values("abort_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Keypad-side controller of the on-screen calculator. It converts debounced navigation and select pulses into a 4×4 cursor position, an editable 16-character expression buffer and a left-to-right evaluated 16-bit result. Its outputs drive the LCD picture generator directly: `cursor_x`/`cursor_y`, `disp_str_flat`, `result` and `calc_done`.

## Interface
- `MAX_LEN`, default 16: expression buffer depth in characters. `disp_str_flat` width is 8*MAX_LEN.
- `clk_in`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  single-cycle, already-debounced move pulses.
- `btn_ok`  in  1  single-cycle select pulse; presses the key under the cursor.
- `cursor_x`, `cursor_y`  out  4 each  column/row of the highlighted key, range 0..3.
- `disp_str_flat`  out  8*MAX_LEN  ASCII buffer. Char k is at bits [k*8 +: 8], k=0 leftmost. Unused slots are 8'h20.
- `result`  out  16  last evaluated value, unsigned.
- `calc_done`  out  1  high while `result` corresponds to the current buffer.
- `busy`  out  1  high during evaluation.

## Operation
- Key map (row,col): r0 "1 2 3 +"; r1 "4 5 6 -"; r2 "7 8 9 *"; r3 "C 0 = B" (B = backspace).
- Reset values: cursor 0,0; buffer all 8'h20; `len` 0; `result` 0; `calc_done` 0; `busy` 0; state IDLE.
- States are IDLE and EVAL.
- IDLE handles one button per cycle. Priority: ok > up > down > left > right. Lower-priority simultaneous pulses are dropped.
- Moves wrap modulo 4: up at row 0 goes to row 3; right at col 3 goes to col 0.
- ok on a digit or operator: if len<MAX_LEN, write the char at index len and increment len. If full, do nothing.
- ok on B: if len>0, set slot len-1 to 8'h20 and decrement len. If empty, do nothing.
- ok on C: clear the buffer, len=0, result=0, calc_done=0.
- ok on "=": enter EVAL with idx=0, acc=0, opnd=0, op='+'. Set busy=1.
- Any buffer-editing ok (digit, operator, B) clears calc_done. The buffer itself is retained. Cursor moves do not affect calc_done.
- EVAL consumes one char per cycle at index idx:
  - digit d: opnd = opnd*10 + d, mod 2^16.
  - operator: acc = acc op opnd, mod 2^16; op = new operator; opnd = 0.
- EVAL finish cycle (idx==len): result = acc op opnd; calc_done=1; busy=0; return to IDLE.
- Arithmetic:
  - No precedence; evaluation is strictly left-to-right.
  - Subtraction wraps (0-5 = 65531).
  - Multiply keeps the low 16 bits.
  - An empty operand counts as 0, so a leading, doubled or trailing operator is legal.
- All button inputs are ignored while busy, including the cycle EVAL exits.

## Timing
- Moves and edits: outputs update on the edge that samples the pulse. Latency is 1 cycle.
- "=" sampled at edge E0: busy is high from E0. Chars are consumed at edges E1..E_len. result, calc_done=1 and busy=0 all appear at E_(len+1).
- len=0: result=0 and calc_done=1 at E1.
- Reset asserted mid-EVAL: immediate return to reset values. No partial result is exposed.
- result holds its value between evaluations. It changes only on EVAL finish, C, or reset.

## Structure
- `calc_pkg` contains:
  - key-map function (row,col) to ASCII
  - char constants: SPACE=8'h20, '+', '-', '*', 'C', '=', 'B'
  - state enum {IDLE, EVAL}
  - MAX_LEN default
- Sub-module `calc_eval` holds the char-at-a-time accumulator datapath (acc, opnd, op, digit multiply-add).
  - Ports: start, char in, last flag, result, done.
  - `calc_ctrl` owns the cursor, the buffer, len and the FSM.

## Test plan
- Reset, then 5×right, then 6×up → cursor (1,2). Check wrap in both axes.
- Enter "12+3*2" then "=" → result=30. calc_done rises exactly 7 cycles after the "=" edge. busy is high for those 7 cycles.
- "9-12=" → 65533. "999*999=" → 14961. "5+=" → 5. "=" on empty buffer → 0 one cycle later.
- Append 17 digits → len=16 and the 17th is ignored. Then 17×B → buffer all 8'h20 and no underflow.
- After a result: press B → calc_done=0, result unchanged. Press C → result=0.
- Pulse btn_ok and btn_right together during EVAL → ignored. Assert sys_rst mid-EVAL → all outputs at reset values within the same cycle.
